// File: rtl/axi4_lite_arbiter_rd.sv
// Two-requester AXI4-lite read arbiter: shares one downstream read slave
// between two upstream masters.
//
// AR is granted round-robin. The grant is held until the handshake. A 1-bit
// in-order route FIFO records which requester issued each AR, and each R beat
// is steered back to that requester.
//
// Optional build macro:
//   AXI4_LITE_ARB_RD_FIXED_PRIORITY_EN - requester 0 wins every AR contention.
//
// Ports (axi4_s_* are indexed [1:0] by requester; axi4_m_* go to the shared slave):
//   aclk, aresetn                      clock / async active-low reset
//   axi4_s_ar{valid,ready,addr,prot,id} upstream AR channels
//   axi4_s_r{valid,ready,data,resp,id}  upstream R channels
//   axi4_m_ar{valid,ready,addr,prot,id} downstream AR channel
//   axi4_m_r{valid,ready,data,resp,id}  downstream R channel
module axi4_lite_arbiter_rd #(
  parameter int unsigned A = 32,
  parameter int unsigned N = 4,
  parameter int unsigned I = 1,
  parameter int unsigned D = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [1:0]            axi4_s_arvalid,
  output logic [1:0]            axi4_s_arready,
  input  logic [1:0][A-1:0]     axi4_s_araddr,
  input  logic [1:0][2:0]       axi4_s_arprot,
  input  logic [1:0][I-1:0]     axi4_s_arid,
  output logic [1:0]            axi4_s_rvalid,
  input  logic [1:0]            axi4_s_rready,
  output logic [1:0][8*N-1:0]   axi4_s_rdata,
  output logic [1:0][1:0]       axi4_s_rresp,
  output logic [1:0][I-1:0]     axi4_s_rid,
  output logic                  axi4_m_arvalid,
  input  logic                  axi4_m_arready,
  output logic [A-1:0]          axi4_m_araddr,
  output logic [2:0]            axi4_m_arprot,
  output logic [I-1:0]          axi4_m_arid,
  input  logic                  axi4_m_rvalid,
  output logic                  axi4_m_rready,
  input  logic [8*N-1:0]        axi4_m_rdata,
  input  logic [1:0]            axi4_m_rresp,
  input  logic [I-1:0]          axi4_m_rid
);

  localparam int unsigned PW = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned CW = $clog2(D + 1);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t         state_q, state_d;
  logic           last_q;
  logic [CW-1:0]  count_q;
  logic [D-1:0]   fifo_q;
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic           sel_c, ar_hs_c, r_hs_c, empty_c, head_c;

  assign sel_c   = (state_q == GRANT1);
  assign ar_hs_c = axi4_m_arvalid & axi4_m_arready;
  assign empty_c = (count_q == '0);
  assign head_c  = fifo_q[rd_ptr_q];
  assign r_hs_c  = axi4_m_rvalid & axi4_m_rready;

  // Next-state: arbitrate in IDLE, hold the grant until the AR handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (count_q < CW'(D)) begin
          if (axi4_s_arvalid == 2'b11) begin
`ifdef AXI4_LITE_ARB_RD_FIXED_PRIORITY_EN
            state_d = GRANT0;
`else
            state_d = last_q ? GRANT0 : GRANT1;
`endif
          end else if (axi4_s_arvalid[0]) begin
            state_d = GRANT0;
          end else if (axi4_s_arvalid[1]) begin
            state_d = GRANT1;
          end
        end
      end
      GRANT0, GRANT1: if (ar_hs_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // AR mux: the granted requester drives the downstream AR channel.
  always_comb begin
    axi4_m_arvalid = (state_q != IDLE);
    axi4_m_araddr  = axi4_s_araddr[sel_c];
    axi4_m_arprot  = axi4_s_arprot[sel_c];
    axi4_m_arid    = axi4_s_arid[sel_c];
    axi4_s_arready = 2'b00;
    if (state_q == GRANT0) axi4_s_arready[0] = axi4_m_arready;
    if (state_q == GRANT1) axi4_s_arready[1] = axi4_m_arready;
  end

  // R steering: the FIFO head selects the requester. An empty FIFO holds off R.
  always_comb begin
    axi4_s_rdata  = {2{axi4_m_rdata}};
    axi4_s_rresp  = {2{axi4_m_rresp}};
    axi4_s_rid    = {2{axi4_m_rid}};
    axi4_s_rvalid = 2'b00;
    axi4_m_rready = 1'b0;
    if (!empty_c) begin
      axi4_s_rvalid[head_c] = axi4_m_rvalid;
      axi4_m_rready         = axi4_s_rready[head_c];
    end
  end

  // State, round-robin pointer, route FIFO and outstanding count.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      count_q  <= '0;
      fifo_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      if (ar_hs_c) begin
        last_q           <= sel_c;
        fifo_q[wr_ptr_q] <= sel_c;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (r_hs_c) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({ar_hs_c, r_hs_c})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_arbiter_rd.sv
module tb_axi4_lite_arbiter_rd;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [1:0]        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0][31:0]  s_araddr, s_rdata;
  logic [1:0][2:0]   s_arprot;
  logic [1:0][0:0]   s_arid, s_rid;
  logic [1:0][1:0]   s_rresp;
  logic              m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0]       m_araddr, m_rdata;
  logic [2:0]        m_arprot;
  logic [0:0]        m_arid, m_rid;
  logic [1:0]        m_rresp;

  always #5 aclk = ~aclk;

  axi4_lite_arbiter_rd #(.A(32), .N(4), .I(1), .D(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .axi4_s_arvalid(s_arvalid), .axi4_s_arready(s_arready), .axi4_s_araddr(s_araddr),
    .axi4_s_arprot(s_arprot), .axi4_s_arid(s_arid),
    .axi4_s_rvalid(s_rvalid), .axi4_s_rready(s_rready), .axi4_s_rdata(s_rdata),
    .axi4_s_rresp(s_rresp), .axi4_s_rid(s_rid),
    .axi4_m_arvalid(m_arvalid), .axi4_m_arready(m_arready), .axi4_m_araddr(m_araddr),
    .axi4_m_arprot(m_arprot), .axi4_m_arid(m_arid),
    .axi4_m_rvalid(m_rvalid), .axi4_m_rready(m_rready), .axi4_m_rdata(m_rdata),
    .axi4_m_rresp(m_rresp), .axi4_m_rid(m_rid)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Requester models: request queues, issue index, enable and rready.
  logic [31:0] req0[$], req1[$], got0[$], got1[$];
  int          idx0, idx1;
  logic [1:0]  en, rready_drv;
  // Slave model: accepted ARs, and pending responses with their earliest cycle.
  logic [31:0] ar_log[$], rq_data[$];
  int          ar_cyc[$], rq_time[$], r_cyc[$];
  bit          withhold;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drive after the rising edge, then sample handshakes at the falling edge.
  task automatic cycle();
    @(posedge aclk);
    #1;
    cyc++;
    s_arvalid[0] = en[0] && (idx0 < req0.size());
    s_arvalid[1] = en[1] && (idx1 < req1.size());
    s_araddr[0]  = s_arvalid[0] ? req0[idx0] : 32'h0;
    s_araddr[1]  = s_arvalid[1] ? req1[idx1] : 32'h0;
    s_rready     = rready_drv;
    m_rvalid     = !withhold && (rq_data.size() > 0) && (rq_time[0] <= cyc);
    m_rdata      = (rq_data.size() > 0) ? rq_data[0] : 32'h0;
    @(negedge aclk);
    if (m_arvalid && m_arready) begin
      ar_log.push_back(m_araddr);
      ar_cyc.push_back(cyc);
      rq_data.push_back(m_araddr);
      rq_time.push_back(cyc + 3);
    end
    if (s_arvalid[0] && s_arready[0]) idx0++;
    if (s_arvalid[1] && s_arready[1]) idx1++;
    if (s_rvalid[0] && s_rready[0]) begin
      got0.push_back(s_rdata[0]);
      check("rresp0", 64'(s_rresp[0]), 64'h0);
    end
    if (s_rvalid[1] && s_rready[1]) begin
      got1.push_back(s_rdata[1]);
      check("rresp1", 64'(s_rresp[1]), 64'h0);
    end
    if (m_rvalid && m_rready) begin
      void'(rq_data.pop_front());
      void'(rq_time.pop_front());
      r_cyc.push_back(cyc);
    end
  endtask

  task automatic reset_assert();
    aresetn = 1'b0;
    req0.delete(); req1.delete(); got0.delete(); got1.delete();
    ar_log.delete(); ar_cyc.delete(); rq_data.delete(); rq_time.delete(); r_cyc.delete();
    idx0 = 0; idx1 = 0; en = 2'b11; rready_drv = 2'b11; withhold = 1'b0;
    s_arvalid = 2'b00; m_rvalid = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    while ((idx0 < req0.size() || idx1 < req1.size() || rq_data.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    check("drain_timeout", 64'(n < budget), 64'h1);
  endtask

  logic [31:0] exp_ord[8];

  initial begin
    aresetn   = 1'b0;
    s_araddr  = '0; s_arprot = '0; s_arid = '0; s_rready = '0;
    m_arready = 1'b1; m_rresp = 2'b00; m_rid = 1'b0; m_rdata = '0;
    reset_assert();

    // Reset held with both requesters pending, then first grant.
    for (int k = 0; k < 4; k++) begin
      req0.push_back(32'(4 * k));
      req1.push_back(32'h100 + 32'(4 * k));
    end
    cycle();
    check("rst_m_arvalid", 64'(m_arvalid), 64'h0);
    check("rst_s_arready", 64'(s_arready), 64'h0);
    check("rst_s_rvalid",  64'(s_rvalid),  64'h0);
    check("rst_m_rready",  64'(m_rready),  64'h0);
    aresetn = 1'b1;
    cycle();
    check("first_grant_valid", 64'(m_arvalid), 64'h1);
    check("first_grant_addr",  64'(m_araddr),  64'h0);
    check("first_grant_ready", 64'(s_arready), 64'h1);

    // Interleaved streaming and response routing.
    run_until_done(300);
    for (int k = 0; k < 4; k++) begin
`ifdef AXI4_LITE_ARB_RD_FIXED_PRIORITY_EN
      exp_ord[k]     = 32'(4 * k);
      exp_ord[k + 4] = 32'h100 + 32'(4 * k);
`else
      exp_ord[2 * k]     = 32'(4 * k);
      exp_ord[2 * k + 1] = 32'h100 + 32'(4 * k);
`endif
    end
    check("ar_count", 64'(ar_log.size()), 64'd8);
    for (int k = 0; k < 8 && k < ar_log.size(); k++) check("ar_order", 64'(ar_log[k]), 64'(exp_ord[k]));
    check("got0_size", 64'(got0.size()), 64'd4);
    check("got1_size", 64'(got1.size()), 64'd4);
    for (int k = 0; k < 4 && k < got0.size(); k++) check("route0", 64'(got0[k]), 64'(4 * k));
    for (int k = 0; k < 4 && k < got1.size(); k++) check("route1", 64'(got1[k]), 64'h100 + 64'(4 * k));

    // Outstanding limit: four reads in flight, fifth waits for an R handshake.
    reset_assert();
    cycle();
    aresetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req0.push_back(32'(4 * k));
      req1.push_back(32'h100 + 32'(4 * k));
    end
    withhold = 1'b1;
    repeat (20) cycle();
    check("limit_ar_count", 64'(ar_log.size()), 64'd4);
    check("limit_no_arvalid", 64'(m_arvalid), 64'h0);
    withhold = 1'b0;
    run_until_done(300);
    check("limit_total_ar", 64'(ar_log.size()), 64'd6);
    if (ar_log.size() > 4 && r_cyc.size() > 0)
      check("fifth_ar_gap", 64'(ar_cyc[4] - r_cyc[0]), 64'd2);
    else
      check("fifth_ar_seen", 64'h0, 64'h1);
    check("limit_got0", 64'(got0.size()), 64'd3);
    check("limit_got1", 64'(got1.size()), 64'd3);

    // Backpressure from requester 1 with its beat at the FIFO head.
    reset_assert();
    cycle();
    aresetn = 1'b1;
    req1.push_back(32'h100);
    req0.push_back(32'h000);
    en = 2'b10;
    rready_drv = 2'b01;
    repeat (3) cycle();
    en = 2'b11;
    repeat (10) begin
      cycle();
      if (m_rvalid) begin
        check("bp_m_rready", 64'(m_rready), 64'h0);
        check("bp_s_rvalid0", 64'(s_rvalid[0]), 64'h0);
      end
    end
    check("bp_pending", 64'(m_rvalid), 64'h1);
    check("bp_s_rvalid1", 64'(s_rvalid[1]), 64'h1);
    check("bp_s_rdata1", 64'(s_rdata[1]), 64'h100);
    check("bp_no_early_beat", 64'(got0.size() + got1.size()), 64'd0);
    rready_drv = 2'b11;
    run_until_done(100);
    check("bp_got1_size", 64'(got1.size()), 64'd1);
    check("bp_got0_size", 64'(got0.size()), 64'd1);
    if (got1.size() > 0) check("bp_got1_data", 64'(got1[0]), 64'h100);
    if (got0.size() > 0) check("bp_got0_data", 64'(got0[0]), 64'h000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
